// File: rtl/bsg_strobe_gen_if.sv
// Interval/strobe bundle for bsg_strobe_gen. The master supplies the interval value and
// observes the strobe; the slave (the generator) consumes the interval and drives the strobe.
interface bsg_strobe_gen_if #(
    parameter int unsigned width_p = 8
) ();
    logic [width_p-1:0] init_val_r;
    logic               strobe_r;

    modport master (
        output init_val_r,
        input  strobe_r
    );

    modport slave (
        input  init_val_r,
        output strobe_r
    );
endinterface

// File: rtl/bsg_strobe_gen.sv
// Programmable periodic strobe: one-cycle pulse every (N+1) cycles, N from the interface.
// Optional simulation checks are compiled in with `define BSG_STROBE_GEN_CHECK_EN.
module bsg_strobe_gen #(
    parameter int unsigned width_p = 8
) (
    input  logic             clk_i,
    input  logic             reset_r_i,
    bsg_strobe_gen_if.slave  bus_io
);
    localparam logic [width_p-1:0] One = {{(width_p-1){1'b0}}, 1'b1};

    logic [width_p-1:0] cnt_q, cnt_d;
    logic [width_p-1:0] init_q;
    logic               strobe_q, strobe_d;

    // Reload uses init_q, i.e. the interval value from the cycle before the strobe cycle.
    always_comb begin
        cnt_d    = (cnt_q == '0) ? init_q : (cnt_q - One);
        strobe_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        init_q <= bus_io.init_val_r;
        if (reset_r_i) begin
            cnt_q    <= bus_io.init_val_r;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus_io.strobe_r = strobe_q;

`ifdef BSG_STROBE_GEN_CHECK_EN
    logic [width_p:0] gap_q;
    logic [width_p:0] exp_gap_q;
    logic             armed_q;

    // gap_q counts cycles since the last strobe; exp_gap_q is 1 + the N reloaded at it.
    always_ff @(posedge clk_i) begin
        if ($isunknown(reset_r_i)) begin
            $error("bsg_strobe_gen: reset_r_i is X/Z");
            $finish;
        end else if (reset_r_i) begin
            armed_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            if ($isunknown(bus_io.init_val_r)) begin
                $error("bsg_strobe_gen: init_val_r_i is X/Z on a non-reset edge");
                $finish;
            end
            gap_q <= gap_q + {{width_p{1'b0}}, 1'b1};
            if (strobe_q) begin
                if (armed_q && (gap_q != exp_gap_q)) begin
                    $error("bsg_strobe_gen: interval %0d, expected %0d", gap_q, exp_gap_q);
                    $finish;
                end
                armed_q   <= 1'b1;
                gap_q     <= {{width_p{1'b0}}, 1'b1};
                exp_gap_q <= {1'b0, init_q} + {{width_p{1'b0}}, 1'b1};
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_bsg_strobe_gen.sv
// Directed and randomized bench for bsg_strobe_gen with a per-cycle expected-strobe scoreboard.
module tb_bsg_strobe_gen;
    logic clk = 1'b0;
    logic reset_r = 1'b1;

    bsg_strobe_gen_if #(.width_p(8)) bus ();

    bsg_strobe_gen #(.width_p(8)) dut (
        .clk_i     (clk),
        .reset_r_i (reset_r),
        .bus_io    (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   sb[$];
    int   k = 0;        // post-reset index of the next cycle
    int   next_s = 0;   // post-reset index of the next expected strobe

    // Drive one cycle of inputs, predict the strobe for the following cycle, then compare.
    task automatic step(input bit rst, input logic [7:0] n, input string tag);
        bit e;
        bit exp_v;
        logic obs;
        reset_r        = rst;
        bus.init_val_r = n;
        if (rst) begin
            e      = 1'b0;
            k      = 1;
            next_s = (n == 8'd0) ? 2 : int'(n) + 1;
        end else begin
            k++;
            e = (k == next_s);
            // Next interval is 1 + N held in the cycle preceding this strobe (this cycle).
            if (e) next_s = k + 1 + int'(n);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        obs   = bus.strobe_r;
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, obs, exp_v);
        end
    endtask

    task automatic run(input int cycles, input logic [7:0] n, input string tag);
        for (int i = 0; i < cycles; i++) step(1'b0, n, tag);
    endtask

    initial begin
        logic [7:0] sweep_n [10];
        logic [7:0] rn;
        sweep_n = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd31, 8'd64, 8'd128, 8'd200};

        // N=0: low in post-reset cycle 1, then high every cycle
        step(1'b1, 8'd0, "n0_reset");
        run(20, 8'd0, "n0_run");

        // N=5: strobes at 6, 12, 18, ...
        step(1'b1, 8'd5, "n5_reset");
        run(40, 8'd5, "n5_run");

        // Sweep several intervals without intervening reset
        foreach (sweep_n[i]) run(8 * (int'(sweep_n[i]) + 1), sweep_n[i], "sweep");

        // N=3, switch to 10 one cycle after a strobe: intervals 4 then 11
        step(1'b1, 8'd3, "chg_reset");
        run(4, 8'd3, "chg_n3");
        run(30, 8'd10, "chg_n10");

        // Maximum interval: 256-cycle period, wrap without spurious pulse
        step(1'b1, 8'd255, "max_reset");
        run(800, 8'd255, "max_run");

        // Reset mid-countdown, held 3 cycles
        step(1'b1, 8'd7, "mid_reset0");
        run(3, 8'd7, "mid_pre");
        for (int i = 0; i < 3; i++) step(1'b1, 8'd7, "mid_reset");
        run(30, 8'd7, "mid_post");

        // Random interval changes, including near-strobe updates
        step(1'b1, 8'd4, "rnd_reset");
        for (int j = 0; j < 200; j++) begin
            rn = 8'($urandom_range(0, 12));
            run(int'($urandom_range(1, 15)), rn, "rnd_run");
        end

        // Short reset pulse during an N=0 stream
        step(1'b1, 8'd0, "n0b_reset");
        run(5, 8'd0, "n0b_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
